// File: rtl/subservient_pkg.sv
// Shared definitions for the subservient Wishbone bus blocks.
//   region_t      : peripheral region carried in CPU address bits [31:30]
//   state_t       : request/response FSM encodings used by bus stages
//   decode_region : maps the two region address bits onto region_t
package subservient_pkg;

  typedef enum logic [1:0] {
    REG_UNMAPPED = 2'b00,
    REG_GPIO     = 2'b01,
    REG_TIMER    = 2'b10,
    REG_EXT      = 2'b11
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic region_t decode_region(input logic [1:0] adr_hi);
    return region_t'(adr_hi);
  endfunction

endpackage

// File: rtl/subservient_wb_timeout.sv
// Saturating wait-state counter for bus timeouts.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : return count to zero (has priority over i_en)
//   i_en         : advance by one; holds once TIMEOUT is reached
//   o_expired    : high while the count equals TIMEOUT
module subservient_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count <= '0;
    end else if (i_en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign o_expired = (count == LIMIT);

endmodule

// File: rtl/subservient_periph_decoder.sv
// Peripheral decoder and response stage between the SERV data bus and the
// GPIO, timer and external Wishbone slaves.
//   i_wb_cpu_*   : CPU request (adr/dat/sel/we/stb) and response (rdt/ack)
//   o_wb_gpio_*  : GPIO slave request, i_wb_gpio_rdt/ack its response
//   o_wb_timer_* : timer slave request, i_wb_timer_rdt/ack its response
//   o_wb_ext_*   : external slot request, i_wb_ext_rdt/ack its response
//   o_timeout    : sticky flag, set whenever a slave had to be cut off
//
// Handshake: the CPU raises stb and holds adr/dat/sel/we stable until it sees
// a one-cycle ack; rdt is valid only in that ack cycle. Each slave stb stays
// high until the slave acks (or the wait budget runs out); a slave ack counts
// only while its own stb is high.
module subservient_periph_decoder
  import subservient_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic [31:0] i_wb_cpu_adr,
  input  logic [31:0] i_wb_cpu_dat,
  input  logic [3:0]  i_wb_cpu_sel,
  input  logic        i_wb_cpu_we,
  input  logic        i_wb_cpu_stb,
  output logic [31:0] o_wb_cpu_rdt,
  output logic        o_wb_cpu_ack,
  output logic        o_wb_gpio_dat,
  output logic        o_wb_gpio_we,
  output logic        o_wb_gpio_stb,
  input  logic        i_wb_gpio_rdt,
  input  logic        i_wb_gpio_ack,
  output logic [31:0] o_wb_timer_dat,
  output logic [3:0]  o_wb_timer_sel,
  output logic        o_wb_timer_we,
  output logic        o_wb_timer_stb,
  input  logic [31:0] i_wb_timer_rdt,
  input  logic        i_wb_timer_ack,
  output logic [29:0] o_wb_ext_adr,
  output logic [31:0] o_wb_ext_dat,
  output logic [3:0]  o_wb_ext_sel,
  output logic        o_wb_ext_we,
  output logic        o_wb_ext_stb,
  input  logic [31:0] i_wb_ext_rdt,
  input  logic        i_wb_ext_ack,
  output logic        o_timeout
);

  state_t      state, state_nxt;
  region_t     region_q;
  region_t     cpu_region;
  logic [31:0] rdt_q, rdt_nxt;
  logic        timeout_q, set_timeout;
  logic        cnt_clr, cnt_en, expired;
  logic        sel_ack;
  logic [31:0] sel_rdt;

  assign cpu_region = decode_region(i_wb_cpu_adr[31:30]);

  subservient_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_wb_clk),
    .i_rst     (i_wb_rst),
    .i_clr     (cnt_clr),
    .i_en      (cnt_en),
    .o_expired (expired)
  );

  // Response of whichever slave was latched at request time; the others are
  // never looked at, so stray acks from idle slaves cannot end a transfer.
  always_comb begin
    sel_ack = 1'b0;
    sel_rdt = '0;
    case (region_q)
      REG_GPIO: begin
        sel_ack = i_wb_gpio_ack;
        sel_rdt = {31'b0, i_wb_gpio_rdt};
      end
      REG_TIMER: begin
        sel_ack = i_wb_timer_ack;
        sel_rdt = i_wb_timer_rdt;
      end
      REG_EXT: begin
        sel_ack = i_wb_ext_ack;
        sel_rdt = i_wb_ext_rdt;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    rdt_nxt     = rdt_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_wb_cpu_stb) begin
          if (cpu_region == REG_UNMAPPED) begin
            rdt_nxt   = '0;
            state_nxt = ST_RESP;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // A slave ack in the expiry cycle still counts as a normal completion.
        if (sel_ack) begin
          rdt_nxt   = sel_rdt;
          state_nxt = ST_RESP;
        end else if (expired) begin
          rdt_nxt     = '0;
          set_timeout = 1'b1;
          state_nxt   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state     <= ST_IDLE;
      region_q  <= REG_UNMAPPED;
      rdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdt_q <= rdt_nxt;
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if ((state == ST_IDLE) && i_wb_cpu_stb) begin
        region_q <= cpu_region;
      end
    end
  end

  assign o_wb_cpu_ack   = (state == ST_RESP);
  assign o_wb_cpu_rdt   = rdt_q;
  assign o_timeout      = timeout_q;

  assign o_wb_gpio_stb  = (state == ST_WAIT) && (region_q == REG_GPIO);
  assign o_wb_timer_stb = (state == ST_WAIT) && (region_q == REG_TIMER);
  assign o_wb_ext_stb   = (state == ST_WAIT) && (region_q == REG_EXT);

  // Request fields go straight through; the CPU holds them until ack.
  assign o_wb_gpio_dat  = i_wb_cpu_dat[0];
  assign o_wb_gpio_we   = i_wb_cpu_we;
  assign o_wb_timer_dat = i_wb_cpu_dat;
  assign o_wb_timer_sel = i_wb_cpu_sel;
  assign o_wb_timer_we  = i_wb_cpu_we;
  assign o_wb_ext_adr   = i_wb_cpu_adr[29:0];
  assign o_wb_ext_dat   = i_wb_cpu_dat;
  assign o_wb_ext_sel   = i_wb_cpu_sel;
  assign o_wb_ext_we    = i_wb_cpu_we;

endmodule

// File: tb/tb_subservient_periph_decoder.sv
module tb_subservient_periph_decoder;
  import subservient_pkg::*;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [31:0] cpu_adr, cpu_dat, cpu_rdt;
  logic [3:0]  cpu_sel;
  logic        cpu_we, cpu_stb, cpu_ack;
  logic        gpio_dat, gpio_we, gpio_stb, gpio_rdt, gpio_ack;
  logic [31:0] timer_dat, timer_rdt;
  logic [3:0]  timer_sel;
  logic        timer_we, timer_stb, timer_ack;
  logic [29:0] ext_adr;
  logic [31:0] ext_dat, ext_rdt;
  logic [3:0]  ext_sel;
  logic        ext_we, ext_stb, ext_ack;
  logic        timeout;

  subservient_periph_decoder #(.TIMEOUT(TO)) dut (
    .i_wb_clk       (clk),
    .i_wb_rst       (rst),
    .i_wb_cpu_adr   (cpu_adr),
    .i_wb_cpu_dat   (cpu_dat),
    .i_wb_cpu_sel   (cpu_sel),
    .i_wb_cpu_we    (cpu_we),
    .i_wb_cpu_stb   (cpu_stb),
    .o_wb_cpu_rdt   (cpu_rdt),
    .o_wb_cpu_ack   (cpu_ack),
    .o_wb_gpio_dat  (gpio_dat),
    .o_wb_gpio_we   (gpio_we),
    .o_wb_gpio_stb  (gpio_stb),
    .i_wb_gpio_rdt  (gpio_rdt),
    .i_wb_gpio_ack  (gpio_ack),
    .o_wb_timer_dat (timer_dat),
    .o_wb_timer_sel (timer_sel),
    .o_wb_timer_we  (timer_we),
    .o_wb_timer_stb (timer_stb),
    .i_wb_timer_rdt (timer_rdt),
    .i_wb_timer_ack (timer_ack),
    .o_wb_ext_adr   (ext_adr),
    .o_wb_ext_dat   (ext_dat),
    .o_wb_ext_sel   (ext_sel),
    .o_wb_ext_we    (ext_we),
    .o_wb_ext_stb   (ext_stb),
    .i_wb_ext_rdt   (ext_rdt),
    .i_wb_ext_ack   (ext_ack),
    .o_timeout      (timeout)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // Expected transaction timeline (absolute cycle numbers).
  int          c0;
  int          exp_ack_cyc = -1;
  logic [31:0] exp_rdt = '0;
  logic        exp_to = 1'b0;
  region_t     exp_reg = REG_UNMAPPED;
  int          stb_first = 1;
  int          stb_last = 0;
  int          rst_eff = -1;
  logic [31:0] model_rdt = '0;
  logic        model_to = 1'b0;
  logic        cmp_en = 1'b0;
  logic        gpio_reg = 1'b0;
  logic [31:0] exp_q[$];

  // Slave behaviour: selected slave acks in cycle ack_at with resp_data.
  region_t     resp_reg = REG_UNMAPPED;
  int          ack_at = -1;
  logic [31:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // ---------------- slave responders ----------------
  initial begin
    gpio_ack = 1'b0; timer_ack = 1'b0; ext_ack = 1'b0;
    gpio_rdt = 1'b0; timer_rdt = '0; ext_rdt = '0;
    forever begin
      @(posedge clk); #1;
      gpio_ack = 1'b0; timer_ack = 1'b0; ext_ack = 1'b0;
      gpio_rdt = 1'($urandom()); timer_rdt = $urandom(); ext_rdt = $urandom();
      // Stray acks on slaves that are not the current target.
      if (resp_reg != REG_GPIO  && $urandom_range(0, 3) == 0) gpio_ack  = 1'b1;
      if (resp_reg != REG_TIMER && $urandom_range(0, 3) == 0) timer_ack = 1'b1;
      if (resp_reg != REG_EXT   && $urandom_range(0, 3) == 0) ext_ack   = 1'b1;
      if (cyc == ack_at) begin
        case (resp_reg)
          REG_GPIO:  begin gpio_ack  = 1'b1; gpio_rdt  = resp_data[0]; end
          REG_TIMER: begin timer_ack = 1'b1; timer_rdt = resp_data;    end
          REG_EXT:   begin ext_ack   = 1'b1; ext_rdt   = resp_data;    end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic in_win;
        if (cyc == rst_eff) begin
          model_rdt = '0;
          model_to  = 1'b0;
        end
        if (cyc == exp_ack_cyc) begin
          model_rdt = exp_q.size() > 0 ? exp_q.pop_front() : exp_rdt;
          if (exp_to) model_to = 1'b1;
        end
        in_win = (cyc >= stb_first) && (cyc <= stb_last);
        chk("cpu_ack",   32'(cpu_ack),   32'(cyc == exp_ack_cyc));
        chk("cpu_rdt",   cpu_rdt,        model_rdt);
        chk("o_timeout", 32'(timeout),   32'(model_to));
        chk("gpio_stb",  32'(gpio_stb),  32'(in_win && exp_reg == REG_GPIO));
        chk("timer_stb", 32'(timer_stb), 32'(in_win && exp_reg == REG_TIMER));
        chk("ext_stb",   32'(ext_stb),   32'(in_win && exp_reg == REG_EXT));
        chk("gpio_dat",  32'(gpio_dat),  32'(cpu_dat[0]));
        chk("gpio_we",   32'(gpio_we),   32'(cpu_we));
        chk("timer_dat", timer_dat,      cpu_dat);
        chk("timer_sel", 32'(timer_sel), 32'(cpu_sel));
        chk("timer_we",  32'(timer_we),  32'(cpu_we));
        chk("ext_adr",   32'(ext_adr),   {2'b00, cpu_adr[29:0]});
        chk("ext_dat",   ext_dat,        cpu_dat);
        chk("ext_sel",   32'(ext_sel),   32'(cpu_sel));
        chk("ext_we",    32'(ext_we),    32'(cpu_we));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // delay: cycles from slave stb rise to slave ack (1..TO), 0 = never acks.
  task automatic start_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int delay, input logic [31:0] data);
    region_t r;
    int      d;
    logic    acks;
    @(posedge clk); #1;
    cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_stb = 1'b1;
    c0 = cyc;
    r = region_t'(adr[31:30]);
    exp_reg  = r;
    resp_reg = r;
    if (r == REG_UNMAPPED) begin
      ack_at = -1; stb_first = 1; stb_last = 0;
      exp_ack_cyc = c0 + 1; exp_rdt = '0; exp_to = 1'b0;
    end else begin
      acks = (delay >= 1) && (delay <= TO);
      d = acks ? delay : TO;
      resp_data = data;
      ack_at = acks ? c0 + 1 + delay : -1;
      stb_first = c0 + 1;
      stb_last  = c0 + 1 + d;
      exp_ack_cyc = c0 + 2 + d;
      exp_to  = !acks;
      exp_rdt = !acks ? 32'h0 : (r == REG_GPIO ? {31'b0, data[0]} : data);
      if (r == REG_GPIO && we && acks) gpio_reg = dat[0];
    end
  endtask

  task automatic wait_ack(output int lat, output logic [31:0] r);
    bit got;
    got = 1'b0; lat = -1; r = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        got = 1'b1; lat = cyc - c0; r = cpu_rdt;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait: no cpu ack within 40 cycles of cycle %0d", c0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cpu_stb = 1'b0;
      cpu_adr = $urandom(); cpu_dat = $urandom();
      cpu_sel = 4'($urandom()); cpu_we = 1'($urandom());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int          lat;
    logic [31:0] r, a, dd, rd;
    logic        we;
    int          dl;
    rst = 1'b1; cpu_stb = 1'b0; cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",       32'(cpu_ack),   32'd0);
    chk("rst_rdt",       cpu_rdt,        32'd0);
    chk("rst_timeout",   32'(timeout),   32'd0);
    chk("rst_stbs",      32'({gpio_stb, timer_stb, ext_stb}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cmp_en = 1'b1;

    // GPIO write then readback
    start_txn(32'h4000_0000, 1'b1, 32'h0000_0001, 4'hF, 1, $urandom());
    wait_ack(lat, r);
    chk("gpio_wr_lat", 32'(lat), 32'd3);
    rd = $urandom(); rd[0] = gpio_reg;
    start_txn(32'h4000_0000, 1'b0, $urandom(), 4'hF, 1, rd);
    wait_ack(lat, r);
    chk("gpio_rd_rdt", r, 32'h0000_0001);
    chk("gpio_rd_lat", 32'(lat), 32'd3);

    // Timer read, slave acks 5 cycles after stb
    idle(1);
    start_txn(32'h8000_0004, 1'b0, $urandom(), 4'hF, 5, 32'hA5A5_1234);
    wait_ack(lat, r);
    chk("timer_lat", 32'(lat), 32'd7);
    chk("timer_rdt", r, 32'hA5A5_1234);
    chk("timer_to",  32'(timeout), 32'd0);

    // Unmapped read
    start_txn(32'h0000_0010, 1'b0, $urandom(), 4'hF, 1, $urandom());
    wait_ack(lat, r);
    chk("unmap_lat", 32'(lat), 32'd1);
    chk("unmap_rdt", r, 32'd0);
    chk("unmap_to",  32'(timeout), 32'd0);

    // Ext ack lands exactly in the expiry cycle
    start_txn(32'hC000_0100, 1'b0, $urandom(), 4'hF, TO, 32'h1357_9BDF);
    wait_ack(lat, r);
    chk("edge_lat", 32'(lat), 32'd10);
    chk("edge_rdt", r, 32'h1357_9BDF);
    chk("edge_to",  32'(timeout), 32'd0);

    // Ext never acks
    start_txn(32'hC000_0200, 1'b0, $urandom(), 4'hF, 0, $urandom());
    wait_ack(lat, r);
    chk("to_lat", 32'(lat), 32'd10);
    chk("to_rdt", r, 32'd0);
    chk("to_flag", 32'(timeout), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      a  = $urandom();
      we = 1'($urandom());
      dd = $urandom();
      dl = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
      rd = $urandom();
      if (a[31:30] == 2'b01 && !we) rd[0] = gpio_reg;
      idle($urandom_range(0, 2));
      start_txn(a, we, dd, 4'($urandom()), dl, rd);
      wait_ack(lat, r);
    end
    chk("to_sticky", 32'(timeout), 32'd1);

    // Reset while waiting on the timer; its ack then arrives late
    idle(1);
    start_txn(32'h8000_0008, 1'b0, $urandom(), 4'hF, 4, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; cpu_stb = 1'b0;
    stb_last = cyc; exp_ack_cyc = -1; rst_eff = cyc + 1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    @(negedge clk);
    chk("post_rst_to",  32'(timeout), 32'd0);
    chk("post_rst_rdt", cpu_rdt, 32'd0);
    start_txn(32'h4000_0000, 1'b1, 32'h0000_0000, 4'hF, 1, $urandom());
    wait_ack(lat, r);
    chk("post_rst_gpio_lat", 32'(lat), 32'd3);
    idle(3);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
